// File: rtl/cache_cpu_master.sv
// CPU-side initiator for the cache CPU interface: buffers read/write commands in a
// small FIFO, issues them one at a time, and returns completions with statistics.
module cache_cpu_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0] cpu_address,
  output logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_read_en,
  output logic                  cpu_write_en,
  input  logic [DATA_WIDTH-1:0] cpu_read_data,
  input  logic                  cpu_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [15:0]           stall_count,
  output logic [15:0]           req_count
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_n;
  logic                    fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             count;
  logic                    empty, push, pop;

  logic [ADDR_WIDTH-1:0]   address_n;
  logic [DATA_WIDTH-1:0]   write_data_n, rdata_n;
  logic                    read_en_n, write_en_n, write_n, timeout_n;
  logic [15:0]             tcnt, tcnt_n, stall_n, req_n;

  assign empty     = (count == '0);
  assign cmd_ready = (count != DEPTH_C);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n      = state;
    address_n    = cpu_address;
    write_data_n = cpu_write_data;
    read_en_n    = cpu_read_en;
    write_en_n   = cpu_write_en;
    write_n      = rsp_write;
    rdata_n      = rsp_rdata;
    timeout_n    = rsp_timeout;
    tcnt_n       = tcnt;
    stall_n      = stall_count;
    req_n        = req_count;
    case (state)
      S_IDLE: begin
        if (pop) begin
          address_n    = fifo_addr[rd_ptr];
          write_data_n = fifo_wdata[rd_ptr];
          write_n      = fifo_write[rd_ptr];
          read_en_n    = !fifo_write[rd_ptr];
          write_en_n   = fifo_write[rd_ptr];
          state_n      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tcnt_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // cpu_ready is checked first so a completion on the expiry cycle wins
        if (cpu_ready) begin
          rdata_n    = rsp_write ? '0 : cpu_read_data;
          timeout_n  = 1'b0;
          read_en_n  = 1'b0;
          write_en_n = 1'b0;
          req_n      = req_count + 16'd1;
          state_n    = S_RESP;
        end else begin
          if (stall_count != '1) stall_n = stall_count + 16'd1;
          tcnt_n = tcnt + 16'd1;
          if (tcnt == TO_LAST) begin
            rdata_n    = '0;
            timeout_n  = 1'b1;
            read_en_n  = 1'b0;
            write_en_n = 1'b0;
            state_n    = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cpu_address    <= '0;
      cpu_write_data <= '0;
      cpu_read_en    <= 1'b0;
      cpu_write_en   <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_timeout    <= 1'b0;
      tcnt           <= '0;
      stall_count    <= '0;
      req_count      <= '0;
    end else begin
      state          <= state_n;
      cpu_address    <= address_n;
      cpu_write_data <= write_data_n;
      cpu_read_en    <= read_en_n;
      cpu_write_en   <= write_en_n;
      rsp_write      <= write_n;
      rsp_rdata      <= rdata_n;
      rsp_timeout    <= timeout_n;
      tcnt           <= tcnt_n;
      stall_count    <= stall_n;
      req_count      <= req_n;
    end
  end

endmodule

// File: tb/tb_cache_cpu_master.sv
// Directed bench for cache_cpu_master: table of single accesses plus hand-written
// sequences for FIFO backpressure, reset mid-access and read-after-write.
module tb_cache_cpu_master;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [15:0] cpu_address;
  logic [31:0] cpu_write_data, cpu_read_data;
  logic        cpu_read_en, cpu_write_en, cpu_ready;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [15:0] stall_count, req_count;

  cache_cpu_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(11)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
    .stall_count(stall_count), .req_count(req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] cdata;      // data the cache presents on completion
    int          stall;      // WAIT cycles with cpu_ready=0 before completion
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_lat;    // edges from push to first rsp_valid sample
    int          exp_en;     // samples with an enable high
    logic [15:0] exp_req;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t        vecs [5];
  int          checks, errors;
  int          lat, en_cnt, unstable, both;
  int          issue_n, resp_n, low_run, got_w, got_r, wc, bad_en, bad_rsp;
  logic        prev_en, en;
  logic [31:0] hold_rdata;
  logic [31:0] mem [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cpu_read_data = '0; cpu_ready = 1'b0; rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    vecs[0] = '{1'b0, 16'h1234, 32'h0,        32'hDEADBEEF, 0,  32'hDEADBEEF, 1'b0, 3,  2,  16'd1, 16'd0};
    vecs[1] = '{1'b1, 16'h0040, 32'hCAFEF00D, 32'h12345678, 10, 32'h0,        1'b0, 13, 12, 16'd2, 16'd10};
    vecs[2] = '{1'b0, 16'h0BEE, 32'h0,        32'h77777777, 11, 32'h0,        1'b1, 13, 12, 16'd2, 16'd21};
    vecs[3] = '{1'b0, 16'hFFFF, 32'h0,        32'h00000001, 3,  32'h1,        1'b0, 6,  5,  16'd3, 16'd24};
    vecs[4] = '{1'b1, 16'h0000, 32'hFFFFFFFF, 32'h11111111, 0,  32'h0,        1'b0, 3,  2,  16'd4, 16'd24};

    // reset state
    do_reset();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_outputs", {24'(cpu_read_en), cpu_write_en, rsp_valid, rsp_write, rsp_timeout, busy}, 0);
    chk("rst_cpu_address", 32'(cpu_address), 0);
    chk("rst_cpu_wdata", cpu_write_data, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_counters", {stall_count, req_count}, 0);

    // table: one access per record, counters accumulate
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = vecs[i].wr; cmd_addr = vecs[i].addr; cmd_wdata = vecs[i].wdata;
      tick();
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_busy_queued", i), {30'(cpu_read_en), cpu_write_en, busy}, 1);
      tick();
      lat = 2; en_cnt = 0; unstable = 0; both = 0;
      if (cpu_read_en || cpu_write_en) en_cnt++;
      chk($sformatf("v%0d_enables", i), {30'(cpu_read_en), cpu_write_en}, vecs[i].wr ? 1 : 2);
      chk($sformatf("v%0d_addr", i), 32'(cpu_address), 32'(vecs[i].addr));
      chk($sformatf("v%0d_wdata", i), cpu_write_data, vecs[i].wdata);
      for (int it = 0; it < 30; it++) begin
        if (it == 0) begin
          cpu_ready = 1'b1; cpu_read_data = 32'hBAD0BAD0;
        end else begin
          cpu_ready = (it - 1 == vecs[i].stall); cpu_read_data = vecs[i].cdata;
        end
        tick();
        if (cpu_read_en && cpu_write_en) both++;
        if (cpu_read_en || cpu_write_en) begin
          en_cnt++;
          if (cpu_address !== vecs[i].addr || cpu_write_data !== vecs[i].wdata) unstable++;
        end
        if (rsp_valid) break;
        lat++;
      end
      cpu_ready = 1'b0;
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_en_cycles", i), en_cnt, vecs[i].exp_en);
      chk($sformatf("v%0d_stable", i), unstable, 0);
      chk($sformatf("v%0d_both_en", i), both, 0);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_rsp_flags", i), {30'(rsp_write), rsp_timeout}, {30'(vecs[i].wr), vecs[i].exp_to});
      chk($sformatf("v%0d_req_count", i), 32'(req_count), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_stall_count", i), 32'(stall_count), 32'(vecs[i].exp_stall));
      hold_rdata = rsp_rdata;
      tick();
      chk($sformatf("v%0d_rsp_held", i), {31'(rsp_valid), (rsp_rdata == hold_rdata)}, 3);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_done", i), {30'(rsp_valid), busy}, 0);
    end

    // FIFO fill with responses blocked, then drain in order
    do_reset();
    cpu_ready = 1'b1;
    issue_n = 0; resp_n = 0; low_run = 0; prev_en = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc < 5) begin
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100 + 16'(cyc);
        chk($sformatf("t3_cmd_ready_push%0d", cyc), 32'(cmd_ready), 1);
      end else if (cyc < 8) begin
        cmd_valid = 1'b1; cmd_addr = 16'h0BAD;
        chk($sformatf("t3_cmd_ready_full%0d", cyc), 32'(cmd_ready), 0);
      end else begin
        cmd_valid = 1'b0;
      end
      rsp_ready = (cyc >= 8);
      cpu_read_data = {16'hA5A5, cpu_address};
      if (rsp_valid && rsp_ready) begin
        chk($sformatf("t3_rsp%0d", resp_n), rsp_rdata, {16'hA5A5, 16'h0100 + 16'(resp_n)});
        resp_n++;
      end
      tick();
      en = cpu_read_en || cpu_write_en;
      if (en && !prev_en) begin
        chk($sformatf("t3_issue_addr%0d", issue_n), 32'(cpu_address), 32'(16'h0100 + 16'(issue_n)));
        if (issue_n > 0) chk($sformatf("t3_gap%0d", issue_n), 32'(low_run >= 2), 1);
        issue_n++;
      end
      low_run = en ? 0 : low_run + 1;
      prev_en = en;
      if (resp_n == 5 && !busy) break;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("t3_issued", issue_n, 5);
    chk("t3_responses", resp_n, 5);
    chk("t3_req_count", 32'(req_count), 5);

    // reset during WAIT with two commands queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0200 + 16'(i);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    chk("t5_pre_state", {15'(stall_count), cpu_read_en, busy}, {15'd1, 1'b1, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_enables", {30'(cpu_read_en), cpu_write_en}, 0);
    chk("t5_rsp_cmd_busy", {29'(rsp_valid), cmd_ready, busy}, 2);
    chk("t5_counters", {stall_count, req_count}, 0);
    cpu_ready = 1'b1; rsp_ready = 1'b1; bad_en = 0; bad_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_read_en || cpu_write_en) bad_en++;
      if (rsp_valid) bad_rsp++;
    end
    chk("t5_no_stale_access", bad_en, 0);
    chk("t5_no_stale_rsp", bad_rsp, 0);

    // read-after-write through a behavioural cache with one stall per access
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rsp_ready = 1'b1; wc = 0; both = 0; got_w = 0; got_r = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      cmd_valid = (cyc < 2); cmd_write = (cyc == 0); cmd_addr = 16'h00FF;
      cmd_wdata = (cyc == 0) ? 32'h5A5A5A5A : 32'h0;
      wc = (cpu_read_en || cpu_write_en) ? wc + 1 : 0;
      cpu_ready = 1'b0;
      if (wc >= 3) begin
        cpu_ready = 1'b1;
        if (cpu_write_en) mem[cpu_address[7:0]] = cpu_write_data;
        cpu_read_data = mem[cpu_address[7:0]];
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_write) begin
          chk("t6_write_rdata", rsp_rdata, 0);
          got_w++;
        end else begin
          chk("t6_order", got_w, 1);
          chk("t6_read_rdata", rsp_rdata, 32'h5A5A5A5A);
          got_r++;
        end
      end
      tick();
      if (cpu_read_en && cpu_write_en) both++;
      if (got_r == 1 && !busy) break;
    end
    cmd_valid = 1'b0; cpu_ready = 1'b0; rsp_ready = 1'b0;
    chk("t6_responses", {got_w[15:0], got_r[15:0]}, {16'd1, 16'd1});
    chk("t6_both_en", both, 0);
    chk("t6_counters", {stall_count, req_count}, {16'd2, 16'd2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
